// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter: shares the D-cache port between the SQ store head and LQ loads, with retry locking and store anti-starvation
module dcache_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int LQ_IDX_W     = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                mispredict,
    input  logic                sq_request,
    input  logic [63:0]         sq_addr,
    input  logic [63:0]         sq_data,
    input  logic                sq_almost_full,
    input  logic                lq_request,
    input  logic [63:0]         lq_addr,
    input  logic [LQ_IDX_W-1:0] lq_index,
    input  logic                D_cache_success,
    output logic [1:0]          proc2Dcache_command,
    output logic [63:0]         proc2Dcache_addr,
    output logic [63:0]         proc2Dcache_data,
    output logic                store_success,
    output logic                load_success,
    output logic [LQ_IDX_W-1:0] load_success_index,
    output logic [2:0]          starve_cnt
);
    typedef enum logic [1:0] {IDLE, LOCK_ST, LOCK_LD} state_e;
    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;

    state_e     state_q, state_d;
    logic [2:0] starve_q, starve_d;
    logic [1:0] cmd;
    logic       ld_ok, st_win;

    // Pick the issued command, the next lock state and the next starvation count
    always_comb begin
        ld_ok = lq_request & ~mispredict;
        st_win = sq_almost_full | (starve_q >= 3'(STARVE_LIMIT));
        cmd = CMD_NONE;
        case (state_q)
            IDLE:    cmd = (sq_request & (~ld_ok | st_win)) ? CMD_STORE : ld_ok ? CMD_LOAD : CMD_NONE;
            LOCK_ST: cmd = sq_request ? CMD_STORE : CMD_NONE;
            LOCK_LD: cmd = ld_ok ? CMD_LOAD : CMD_NONE;
            default: cmd = CMD_NONE;
        endcase
        if (reset) cmd = CMD_NONE;
        state_d = (cmd != CMD_NONE && !D_cache_success) ? ((cmd == CMD_STORE) ? LOCK_ST : LOCK_LD) : IDLE;
        starve_d = (cmd == CMD_STORE) ? 3'd0 :
                   (cmd == CMD_LOAD && sq_request && starve_q != 3'd7) ? starve_q + 3'd1 : starve_q;
    end

    // State and starvation counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            starve_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    assign proc2Dcache_command = cmd;
    assign proc2Dcache_addr    = (cmd == CMD_STORE) ? sq_addr : (cmd == CMD_LOAD) ? lq_addr : 64'd0;
    assign proc2Dcache_data    = (cmd == CMD_STORE) ? sq_data : 64'd0;
    assign store_success       = D_cache_success & (cmd == CMD_STORE);
    assign load_success        = D_cache_success & (cmd == CMD_LOAD);
    assign load_success_index  = load_success ? lq_index : '0;
    assign starve_cnt          = reset ? 3'd0 : starve_q;
endmodule

// File: tb/tb_dcache_port_arbiter.sv
// tb_dcache_port_arbiter: directed scenario bench for dcache_port_arbiter
module tb_dcache_port_arbiter;
    logic        clock = 1'b0;
    logic        reset, mispredict, sq_request, sq_almost_full, lq_request, D_cache_success;
    logic [63:0] sq_addr, sq_data, lq_addr;
    logic [3:0]  lq_index;
    logic [1:0]  cmd;
    logic [63:0] addr, data;
    logic        ss, ls;
    logic [3:0]  ls_idx;
    logic [2:0]  cnt;
    int          total = 0;
    int          passed = 0;

    always #5 clock = ~clock;

    dcache_port_arbiter #(.STARVE_LIMIT(4), .LQ_IDX_W(4)) dut (
        .clock(clock), .reset(reset), .mispredict(mispredict),
        .sq_request(sq_request), .sq_addr(sq_addr), .sq_data(sq_data), .sq_almost_full(sq_almost_full),
        .lq_request(lq_request), .lq_addr(lq_addr), .lq_index(lq_index),
        .D_cache_success(D_cache_success),
        .proc2Dcache_command(cmd), .proc2Dcache_addr(addr), .proc2Dcache_data(data),
        .store_success(ss), .load_success(ls), .load_success_index(ls_idx), .starve_cnt(cnt)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        mispredict = 0; sq_request = 0; sq_almost_full = 0; lq_request = 0; D_cache_success = 0;
        sq_addr = 0; sq_data = 0; lq_addr = 0; lq_index = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1; sq_request = 1; sq_addr = 64'h55; lq_request = 1; D_cache_success = 1;
        #1;
        total++; if (cmd !== 2'd0) $display("FAIL rst_cmd got %0d exp 0", cmd); else passed++;
        total++; if ({ss, ls} !== 2'b00) $display("FAIL rst_succ got %b exp 00", {ss, ls}); else passed++;
        total++; if (addr !== 64'd0) $display("FAIL rst_addr got %h exp 0", addr); else passed++;
        tick();
        tick();
        total++; if (cnt !== 3'd0) $display("FAIL rst_cnt got %0d exp 0", cnt); else passed++;
        idle_inputs();
        reset = 0;
        tick();
    endtask

    task automatic test_single_store();
        sq_request = 1; sq_addr = 64'hA; sq_data = 64'h3; D_cache_success = 1;
        #1;
        total++; if (cmd !== 2'd2) $display("FAIL st_cmd got %0d exp 2", cmd); else passed++;
        total++; if (addr !== 64'hA || data !== 64'h3) $display("FAIL st_addr_data got %h/%h exp a/3", addr, data); else passed++;
        total++; if (ss !== 1'b1 || ls !== 1'b0) $display("FAIL st_succ got %b%b exp 10", ss, ls); else passed++;
        tick();
        sq_request = 0; lq_request = 1; lq_addr = 64'h40; lq_index = 4'd9;
        #1;
        total++; if (cmd !== 2'd1 || ls_idx !== 4'd9) $display("FAIL st_idle_after got cmd %0d idx %0d exp 1/9", cmd, ls_idx); else passed++;
        total++; if (data !== 64'd0) $display("FAIL ld_data_zero got %h exp 0", data); else passed++;
        tick();
        lq_request = 0; D_cache_success = 1;
        #1;
        total++; if (cmd !== 2'd0 || ss !== 1'b0 || ls !== 1'b0) $display("FAIL none_ignored got cmd %0d ss %b ls %b exp 0/0/0", cmd, ss, ls); else passed++;
        tick();
        idle_inputs();
    endtask

    task automatic test_starvation();
        sq_request = 1; sq_addr = 64'h200; sq_data = 64'h77; lq_request = 1; lq_addr = 64'h100; D_cache_success = 1;
        for (int i = 1; i <= 4; i++) begin
            lq_index = 4'(i + 5);
            #1;
            total++; if (cmd !== 2'd1 || ls !== 1'b1 || ls_idx !== 4'(i + 5) || addr !== 64'h100)
                $display("FAIL starve_ld%0d got cmd %0d ls %b idx %0d addr %h exp 1/1/%0d/100", i, cmd, ls, ls_idx, addr, i + 5);
            else passed++;
            tick();
            total++; if (cnt !== 3'(i)) $display("FAIL starve_cnt%0d got %0d exp %0d", i, cnt, i); else passed++;
        end
        #1;
        total++; if (cmd !== 2'd2 || ss !== 1'b1 || ls !== 1'b0 || ls_idx !== 4'd0) $display("FAIL starve_st got cmd %0d ss %b ls %b idx %0d exp 2/1/0/0", cmd, ss, ls, ls_idx); else passed++;
        tick();
        total++; if (cnt !== 3'd0) $display("FAIL starve_clr got %0d exp 0", cnt); else passed++;
        idle_inputs();
    endtask

    task automatic test_load_lock();
        sq_request = 1; sq_addr = 64'h300; lq_request = 1; lq_addr = 64'h180; lq_index = 4'd3;
        for (int c = 1; c <= 4; c++) begin
            sq_almost_full = (c >= 2);
            D_cache_success = (c == 4);
            #1;
            total++; if (cmd !== 2'd1 || ls !== (c == 4)) $display("FAIL ldlock_c%0d got cmd %0d ls %b exp 1/%0d", c, cmd, ls, c == 4); else passed++;
            tick();
        end
        total++; if (cnt !== 3'd4) $display("FAIL ldlock_cnt got %0d exp 4", cnt); else passed++;
        #1;
        total++; if (cmd !== 2'd2 || ss !== 1'b1) $display("FAIL ldlock_st got cmd %0d ss %b exp 2/1", cmd, ss); else passed++;
        tick();
        idle_inputs();
    endtask

    task automatic test_mispredict();
        lq_request = 1; lq_addr = 64'h1C0; lq_index = 4'd6;
        #1;
        total++; if (cmd !== 2'd1 || ls !== 1'b0) $display("FAIL mp_ld got cmd %0d ls %b exp 1/0", cmd, ls); else passed++;
        tick();
        mispredict = 1; sq_request = 1; sq_addr = 64'h400; sq_data = 64'h9; D_cache_success = 1;
        #1;
        total++; if (cmd !== 2'd0 || ls !== 1'b0 || ss !== 1'b0) $display("FAIL mp_flush got cmd %0d ls %b ss %b exp 0/0/0", cmd, ls, ss); else passed++;
        tick();
        mispredict = 0; lq_request = 0;
        #1;
        total++; if (cmd !== 2'd2 || ss !== 1'b1 || addr !== 64'h400) $display("FAIL mp_st got cmd %0d ss %b addr %h exp 2/1/400", cmd, ss, addr); else passed++;
        tick();
        idle_inputs();
    endtask

    task automatic test_store_lock();
        sq_request = 1; sq_addr = 64'h500; sq_data = 64'h12; lq_addr = 64'h80;
        for (int c = 1; c <= 3; c++) begin
            lq_request = (c >= 2);
            mispredict = (c == 2);
            D_cache_success = (c == 3);
            #1;
            total++; if (cmd !== 2'd2 || ss !== (c == 3) || ls !== 1'b0) $display("FAIL stlock_c%0d got cmd %0d ss %b ls %b exp 2/%0d/0", c, cmd, ss, ls, c == 3); else passed++;
            tick();
            total++; if (cnt !== 3'd0) $display("FAIL stlock_cnt%0d got %0d exp 0", c, cnt); else passed++;
        end
        idle_inputs();
    endtask

    task automatic test_reset_in_lock();
        sq_request = 1; sq_addr = 64'h600; sq_data = 64'h21;
        #1;
        total++; if (cmd !== 2'd2 || ss !== 1'b0) $display("FAIL rl_lock got cmd %0d ss %b exp 2/0", cmd, ss); else passed++;
        tick();
        reset = 1; D_cache_success = 1;
        #1;
        total++; if (cmd !== 2'd0 || ss !== 1'b0 || addr !== 64'd0 || data !== 64'd0) $display("FAIL rl_during got cmd %0d ss %b addr %h data %h exp 0/0/0/0", cmd, ss, addr, data); else passed++;
        tick();
        reset = 0;
        #1;
        total++; if (cnt !== 3'd0) $display("FAIL rl_cnt got %0d exp 0", cnt); else passed++;
        total++; if (cmd !== 2'd2 || ss !== 1'b1 || addr !== 64'h600) $display("FAIL rl_reissue got cmd %0d ss %b addr %h exp 2/1/600", cmd, ss, addr); else passed++;
        tick();
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_store();
        test_starvation();
        test_load_lock();
        test_mispredict();
        test_store_lock();
        test_reset_in_lock();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
